// File: rtl/iter_mag_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cmp_pkg
// Description : Shared definitions for the iterative magnitude comparator:
//               result encodings and the compare-engine FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Result encodings driven on the comparator 'out' port
    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_EQ = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/iter_mag_comparator_cmp_digit.sv
`default_nettype none
// ============================================================================
// Module      : cmp_digit
// Description : Combinational unsigned compare of one DIGIT-bit digit.
// Revision    : 1.0 - initial release
// Ports       : i_a, i_b  DIGIT-bit digits to compare
//               o_gt      i_a > i_b
//               o_lt      i_a < i_b
// ============================================================================
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    output logic             o_gt,
    output logic             o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);

endmodule : cmp_digit
`default_nettype wire

// File: rtl/iter_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : iter_mag_comparator
// Description : Multi-cycle MSB-first magnitude comparator. Examines DIGIT
//               bits per clock, signed or unsigned, and stops at the first
//               differing digit. start/busy/done handshake.
// Revision    : 1.0 - initial release
// Ports       : clk        rising-edge clock
//               rst_n      synchronous active-low reset
//               start      compare request, sampled when not busy
//               is_signed  two's-complement compare, sampled with start
//               in1, in2   operands A and B, sampled with start
//               busy       compare in progress
//               done       one-cycle pulse, out/cycles valid
//               out        10 A>B, 01 A<B, 00 A==B
//               cycles     digits examined for the last result (1..N)
// ============================================================================
module iter_mag_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIGIT = 2,
    localparam int N     = WIDTH / DIGIT,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [1:0]       out,
    output logic [CW-1:0]    cycles
);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
            $error("iter_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    localparam logic [CW-1:0] c_last_digit = CW'(N - 1);

    cmp_state_t       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_out;
    logic [CW-1:0]    r_cycles;

    logic             w_gt;
    logic             w_lt;
    logic [WIDTH-1:0] w_msb_flip;

    // Flipping both sign bits maps two's complement onto offset binary, so
    // the plain unsigned digit compare yields the signed ordering.
    assign w_msb_flip = {is_signed, {(WIDTH-1){1'b0}}};

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_cmp_digit (
        .i_a  (r_sa[WIDTH-1 -: DIGIT]),
        .i_b  (r_sb[WIDTH-1 -: DIGIT]),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= CMP_EQ;
            r_cycles <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // IDLE and DONE both accept a new request; accepting in DONE
                // gives back-to-back operation with no idle bubble.
                IDLE, DONE: begin
                    if (start) begin
                        r_sa    <= in1 ^ w_msb_flip;
                        r_sb    <= in2 ^ w_msb_flip;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CMP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                CMP: begin
                    if (w_gt || w_lt) begin
                        r_out    <= w_gt ? CMP_GT : CMP_LT;
                        r_cycles <= r_cnt + 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else if (r_cnt == c_last_digit) begin
                        r_out    <= CMP_EQ;
                        r_cycles <= CW'(N);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_sa  <= r_sa << DIGIT;
                        r_sb  <= r_sb << DIGIT;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign out    = r_out;
    assign cycles = r_cycles;

endmodule : iter_mag_comparator
`default_nettype wire

// File: tb/tb_iter_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_mag_comparator
// Description : Directed self-checking bench for iter_mag_comparator.
//               8/2 instance for directed vectors, 16/4 and 16/1 instances
//               for a reference-model sweep in both modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_mag_comparator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       is_signed;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy;
    logic       done;
    logic [1:0] out;
    logic [2:0] cycles;

    logic        start4, start1, sgnw;
    logic [15:0] in1w, in2w;
    logic        busy4, done4, busy1, done1;
    logic [1:0]  out4, out1;
    logic [2:0]  cyc4;
    logic [4:0]  cyc1;

    int n_checks = 0;
    int n_pass   = 0;

    iter_mag_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out), .cycles(cycles)
    );

    iter_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgnw),
        .in1(in1w), .in2(in2w), .busy(busy4), .done(done4), .out(out4), .cycles(cyc4)
    );

    iter_mag_comparator #(.WIDTH(16), .DIGIT(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_signed(sgnw),
        .in1(in1w), .in2(in2w), .busy(busy1), .done(done1), .out(out1), .cycles(cyc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One compare on the 8/2 instance; operands and mode are scrambled during
    // CMP to show they are not re-sampled.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sg, input logic [1:0] eo, input int ec);
        int n;
        int busyc;
        @(negedge clk);
        start = 1'b1; in1 = a; in2 = b; is_signed = sg;
        @(negedge clk);
        start = 1'b0; in1 = ~a; in2 = ~b; is_signed = ~sg;
        n = 0;
        busyc = 0;
        while (!done && n < 20) begin
            if (busy) busyc++;
            @(negedge clk);
            n++;
        end
        check({tag, "/done"},    32'(done),   32'd1);
        check({tag, "/latency"}, 32'(n),      32'(ec));
        check({tag, "/out"},     32'(out),    32'(eo));
        check({tag, "/cycles"},  32'(cycles), 32'(ec));
        check({tag, "/busyc"},   32'(busyc),  32'(ec));
        check({tag, "/busy@d"},  32'(busy),   32'd0);
        @(negedge clk);
        check({tag, "/pulse"},   32'(done),   32'd0);
    endtask

    // One compare on a 16-bit instance against an independent reference.
    task automatic run16(input int d, input logic [15:0] a, input logic [15:0] b, input logic sg);
        logic [1:0]  eo;
        logic [15:0] x;
        int          ec;
        int          n;
        logic        dn;
        logic [1:0]  ob;
        int          cb;
        if (sg) eo = ($signed(a) > $signed(b)) ? 2'b10 : ($signed(a) < $signed(b)) ? 2'b01 : 2'b00;
        else    eo = (a > b) ? 2'b10 : (a < b) ? 2'b01 : 2'b00;
        x  = a ^ b;
        ec = 16 / d;
        for (int p = 0; p < 16; p++) if (x[p]) ec = (15 - p) / d + 1;
        @(negedge clk);
        in1w = a; in2w = b; sgnw = sg;
        if (d == 4) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; start1 = 1'b0;
        n = 0;
        dn = 1'b0;
        while (!dn && n < 40) begin
            @(negedge clk);
            n++;
            dn = (d == 4) ? done4 : done1;
        end
        ob = (d == 4) ? out4 : out1;
        cb = (d == 4) ? int'(cyc4) : int'(cyc1);
        check($sformatf("w16d%0d s%0d %h/%h done", d, sg, a, b), 32'(dn), 32'd1);
        check($sformatf("w16d%0d s%0d %h/%h out", d, sg, a, b), 32'(ob), 32'(eo));
        check($sformatf("w16d%0d s%0d %h/%h cyc", d, sg, a, b), 32'(cb), 32'(ec));
        check($sformatf("w16d%0d s%0d %h/%h lat", d, sg, a, b), 32'(n), 32'(ec));
    endtask

    initial begin
        int          ndone;
        int          last_i;
        logic [15:0] a;
        logic [15:0] b;

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0;
        start4 = 1'b0; start1 = 1'b0; sgnw = 1'b0; in1w = '0; in2w = '0;
        repeat (2) @(negedge clk);
        check("rst/busy",   32'(busy),   32'd0);
        check("rst/done",   32'(done),   32'd0);
        check("rst/out",    32'(out),    32'd0);
        check("rst/cycles", 32'(cycles), 32'd0);
        rst_n = 1'b1;

        run8("u80v7F",  8'h80, 8'h7F, 1'b0, 2'b10, 1);
        run8("s80v7F",  8'h80, 8'h7F, 1'b1, 2'b01, 1);
        run8("sFFv00",  8'hFF, 8'h00, 1'b1, 2'b01, 1);
        run8("u44v44",  8'h44, 8'h44, 1'b0, 2'b00, 4);
        run8("u12v13",  8'h12, 8'h13, 1'b0, 2'b01, 4);
        run8("u00v00",  8'h00, 8'h00, 1'b0, 2'b00, 4);
        run8("uFFv00",  8'hFF, 8'h00, 1'b0, 2'b10, 1);
        run8("s7Fv80",  8'h7F, 8'h80, 1'b1, 2'b10, 1);

        // Back-to-back: start held through DONE, plus an ignored mid-CMP start
        @(negedge clk);
        start = 1'b1; in1 = 8'h30; in2 = 8'h20; is_signed = 1'b0;
        @(negedge clk);
        in1 = 8'h05; in2 = 8'h06;
        check("b2b/busy1", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b/nodone", 32'(done), 32'd0);
        @(negedge clk);
        check("b2b/done1", 32'(done),   32'd1);
        check("b2b/out1",  32'(out),    32'(2'b10));
        check("b2b/cyc1",  32'(cycles), 32'd2);
        ndone = 1;
        @(negedge clk);
        in1 = 8'hFF; in2 = 8'h00;
        check("b2b/nobubble", 32'(busy), 32'd1);
        check("b2b/nodone2",  32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        last_i = 0;
        for (int i = 5; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                last_i = i;
            end
        end
        check("b2b/ndone", 32'(ndone),  32'd2);
        check("b2b/when2", 32'(last_i), 32'd7);
        check("b2b/out2",  32'(out),    32'(2'b01));
        check("b2b/cyc2",  32'(cycles), 32'd4);

        // Reset abandons an in-flight compare
        @(negedge clk);
        start = 1'b1; in1 = 8'h12; in2 = 8'h13;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid/busy",   32'(busy),   32'd0);
        check("rstmid/done",   32'(done),   32'd0);
        check("rstmid/out",    32'(out),    32'd0);
        check("rstmid/cycles", 32'(cycles), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rstmid/nodone", 32'(ndone), 32'd0);

        // Parameter sweep: random, single-bit-difference and equal operands
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            case (i % 3)
                0:       b = 16'($urandom);
                1:       b = a ^ (16'd1 << $urandom_range(15, 0));
                default: b = a;
            endcase
            run16(4, a, b, 1'(i % 2));
            run16(1, a, b, 1'(i % 2));
        end
        run16(4, 16'h8000, 16'h7FFF, 1'b1);
        run16(1, 16'h8000, 16'h7FFF, 1'b1);
        run16(1, 16'h0001, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_iter_mag_comparator
`default_nettype wire
